// File: rtl/merge7_pkg.sv
// Shared types for the merge7 packet merge: flit layout and arbiter FSM states.
package merge7_pkg;
  localparam int TAIL_BIT = 8;

  typedef struct packed {
    logic       tail;
    logic [7:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;
endpackage

// File: rtl/merge7_arbiter_if.sv
// Flit/winner-index bundle for merge7_arbiter; slave is the arbiter's view.
interface merge7_arbiter_if
  import merge7_pkg::*;
#(
  parameter int W = $bits(flit_t)
);
  logic [W-1:0] in0_data;
  logic         in0_valid;
  logic         in0_ready;
  logic [W-1:0] in1_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         s_data;
  logic         s_valid;
  logic         s_ready;

  modport slave (
    input  in0_data, in0_valid, in1_data, in1_valid, out_ready, s_ready,
    output in0_ready, in1_ready, out_data, out_valid, s_data, s_valid
  );

  modport master (
    output in0_data, in0_valid, in1_data, in1_valid, out_ready, s_ready,
    input  in0_ready, in1_ready, out_data, out_valid, s_data, s_valid
  );
endinterface

// File: rtl/merge7_fifo.sv
// Shift-register FIFO with registered head data/valid; head always sits in slot 0.
module merge7_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       ready,
  output logic                       valid,
  output logic [W-1:0]               data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem   [DEPTH];
  logic [W-1:0]  mem_n [DEPTH];
  logic [CW-1:0] cnt_n, wr_idx;
  logic          pop;

  assign pop    = valid && ready;
  assign wr_idx = count - CW'(pop);
  assign cnt_n  = count + CW'(push) - CW'(pop);
  assign data   = mem[0];

  // Vacated slots are zeroed so an empty FIFO presents data 0.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_n[i] = mem[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i + 1];
      mem_n[DEPTH-1] = '0;
    end
    if (push)
      for (int i = 0; i < DEPTH; i++)
        if (wr_idx == CW'(i)) mem_n[i] = push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= cnt_n;
      valid <= (cnt_n != '0);
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
    end
  end
endmodule

// File: rtl/merge7_arbiter.sv
// Two-input per-packet round-robin merge with a winner-index side stream.
// Define MERGE7_PKT_CNT_EN to add per-input completed-packet counters.
module merge7_arbiter
  import merge7_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 2
`ifdef MERGE7_PKT_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input logic CLK,
  input logic RESET,
  merge7_arbiter_if.slave io
`ifdef MERGE7_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
`endif
);
  localparam int CW = $clog2(DEPTH + 1);

  state_e        state;
  logic          prio, gnt, s_push, room, s_room;
  logic          xfer0, xfer1, push, tail;
  logic [W-1:0]  flit;
  logic [CW-1:0] out_cnt, s_cnt;

  // Readies come only from registered state and counts, never from out_ready/s_ready.
  assign room         = out_cnt < CW'(DEPTH);
  assign s_room       = s_cnt < CW'(DEPTH);
  assign io.in0_ready = (state == LOCK0) && room;
  assign io.in1_ready = (state == LOCK1) && room;
  assign xfer0        = io.in0_valid && io.in0_ready;
  assign xfer1        = io.in1_valid && io.in1_ready;
  assign push         = xfer0 || xfer1;
  assign flit         = (state == LOCK1) ? io.in1_data : io.in0_data;
  assign tail         = flit[TAIL_BIT];

  assign gnt    = (io.in0_valid && io.in1_valid) ? prio : io.in1_valid;
  assign s_push = (state == IDLE) && (io.in0_valid || io.in1_valid) && s_room;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (s_push) state <= gnt ? LOCK1 : LOCK0;
        LOCK0: if (xfer0 && tail) begin state <= IDLE; prio <= 1'b1; end
        LOCK1: if (xfer1 && tail) begin state <= IDLE; prio <= 1'b0; end
        default: state <= IDLE;
      endcase
    end
  end

  merge7_fifo #(.W(W), .DEPTH(DEPTH)) u_out_fifo (
    .clk(CLK), .rst(RESET), .push(push), .push_data(flit), .ready(io.out_ready),
    .valid(io.out_valid), .data(io.out_data), .count(out_cnt)
  );

  merge7_fifo #(.W(1), .DEPTH(DEPTH)) u_s_fifo (
    .clk(CLK), .rst(RESET), .push(s_push), .push_data(gnt), .ready(io.s_ready),
    .valid(io.s_valid), .data(io.s_data), .count(s_cnt)
  );

`ifdef MERGE7_PKT_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (xfer0 && tail) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (xfer1 && tail) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_merge7_arbiter.sv
// Directed scoreboard bench for merge7_arbiter (optionally with MERGE7_PKT_CNT_EN).
module tb_merge7_arbiter;
  localparam int W     = 9;
  localparam int DEPTH = 2;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  merge7_arbiter_if #(.W(W)) b ();

`ifdef MERGE7_PKT_CNT_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
  merge7_arbiter #(.W(W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .io(b), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );
`else
  merge7_arbiter #(.W(W), .DEPTH(DEPTH)) dut (.CLK(CLK), .RESET(RESET), .io(b));
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [W-1:0] src0_q[$], src1_q[$], exp_out[$];
  logic         exp_s[$];
  logic         xf0 = 1'b0, xf1 = 1'b0;
  int           acc0 = 0, acc1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source drivers: hold valid/data until the transfer, then present the next flit.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      b.in0_valid = 1'b0; b.in0_data = '0;
    end else begin
      #1;
      if (xf0) b.in0_valid = 1'b0;
      if (!b.in0_valid && src0_q.size() > 0) begin
        b.in0_data = src0_q.pop_front(); b.in0_valid = 1'b1;
      end
    end
  end

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      b.in1_valid = 1'b0; b.in1_data = '0;
    end else begin
      #1;
      if (xf1) b.in1_valid = 1'b0;
      if (!b.in1_valid && src1_q.size() > 0) begin
        b.in1_data = src1_q.pop_front(); b.in1_valid = 1'b1;
      end
    end
  end

  // Monitor: handshakes seen at the falling edge complete on the next rising edge.
  always @(negedge CLK) begin
    xf0 = b.in0_valid && b.in0_ready;
    xf1 = b.in1_valid && b.in1_ready;
    if (RESET) begin
      acc0 = 0; acc1 = 0;
    end else begin
      if (xf0) acc0++;
      if (xf1) acc1++;
      if (b.out_valid && b.out_ready) begin
        chk("out_pending", 32'(exp_out.size() > 0), 32'd1);
        if (exp_out.size() > 0) chk("out_data", 32'(b.out_data), 32'(exp_out.pop_front()));
      end
      if (b.s_valid && b.s_ready) begin
        chk("s_pending", 32'(exp_s.size() > 0), 32'd1);
        if (exp_s.size() > 0) chk("s_data", 32'(b.s_data), 32'(exp_s.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_all();
    src0_q.delete(); src1_q.delete(); exp_out.delete(); exp_s.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clear_all();
    repeat (2) step();
    RESET = 1'b0;
    step();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((src0_q.size() + src1_q.size() + exp_out.size() + exp_s.size()) != 0 && n < 300) begin
      step();
      n++;
    end
    chk(tag, 32'(n < 300), 32'd1);
  endtask

  initial begin
    logic [W-1:0] p0 [4];
    b.out_ready = 1'b1;
    b.s_ready   = 1'b1;

    // Reset state
    RESET = 1'b1;
    repeat (2) step();
    chk("rst_in0_ready", 32'(b.in0_ready), 32'd0);
    chk("rst_in1_ready", 32'(b.in1_ready), 32'd0);
    chk("rst_out_valid", 32'(b.out_valid), 32'd0);
    chk("rst_s_valid",   32'(b.s_valid),   32'd0);
    chk("rst_out_data",  32'(b.out_data),  32'd0);
    chk("rst_s_data",    32'(b.s_data),    32'd0);
    RESET = 1'b0;
    step();

    // Single 3-flit packet on in0 with latency checks
    p0 = '{9'h011, 9'h022, 9'h133, 9'h000};
    for (int i = 0; i < 3; i++) begin src0_q.push_back(p0[i]); exp_out.push_back(p0[i]); end
    exp_s.push_back(1'b0);
    step();
    chk("t1_s_valid_early", 32'(b.s_valid), 32'd0);
    chk("t1_ready_idle", 32'(b.in0_ready), 32'd0);
    step();
    chk("t1_s_valid", 32'(b.s_valid), 32'd1);
    chk("t1_in0_ready", 32'(b.in0_ready), 32'd1);
    chk("t1_out_valid_early", 32'(b.out_valid), 32'd0);
    step();
    chk("t1_out_valid", 32'(b.out_valid), 32'd1);
    chk("t1_out_head", 32'(b.out_data), 32'h011);
    wait_drain("t1_drain");
`ifdef MERGE7_PKT_CNT_EN
    chk("t1_pkt_cnt0", 32'(pkt_cnt0), 32'd1);
`endif

    // Both inputs offer single-flit packets continuously: strict alternation
    do_reset();
    for (int i = 0; i < 3; i++) begin
      src0_q.push_back(9'h1A0); src1_q.push_back(9'h1B1);
      exp_out.push_back(9'h1A0); exp_out.push_back(9'h1B1);
      exp_s.push_back(1'b0); exp_s.push_back(1'b1);
    end
    wait_drain("t2_drain");
`ifdef MERGE7_PKT_CNT_EN
    chk("t2_pkt_cnt0", 32'(pkt_cnt0), 32'd3);
    chk("t2_pkt_cnt1", 32'(pkt_cnt1), 32'd3);
`endif

    // in1 arrives mid-packet on in0: no interleaving
    do_reset();
    p0 = '{9'h001, 9'h002, 9'h003, 9'h104};
    for (int i = 0; i < 4; i++) begin src0_q.push_back(p0[i]); exp_out.push_back(p0[i]); end
    exp_out.push_back(9'h1C5);
    exp_s.push_back(1'b0); exp_s.push_back(1'b1);
    repeat (3) step();
    src1_q.push_back(9'h1C5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_in1_ready_held", 32'(b.in1_ready), 32'd0);
    end
    wait_drain("t3_drain");

    // Output backpressure: only DEPTH flits accepted until out_ready returns
    do_reset();
    b.out_ready = 1'b0;
    p0 = '{9'h041, 9'h042, 9'h043, 9'h044};
    for (int i = 0; i < 4; i++) begin src0_q.push_back(p0[i]); exp_out.push_back(p0[i]); end
    src0_q.push_back(9'h145); exp_out.push_back(9'h145);
    exp_s.push_back(1'b0);
    repeat (8) step();
    chk("t4_accepted", 32'(acc0), 32'(DEPTH));
    chk("t4_in0_ready", 32'(b.in0_ready), 32'd0);
    chk("t4_out_valid", 32'(b.out_valid), 32'd1);
    chk("t4_out_head", 32'(b.out_data), 32'h041);
    b.out_ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_total", 32'(acc0), 32'd5);

    // S backpressure: third grant stalls in IDLE
    do_reset();
    b.s_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src0_q.push_back(9'h151 + 9'(i)); exp_out.push_back(9'h151 + 9'(i)); exp_s.push_back(1'b0);
    end
    repeat (10) step();
    chk("t5_granted", 32'(acc0), 32'd2);
    chk("t5_in0_ready", 32'(b.in0_ready), 32'd0);
    chk("t5_s_valid", 32'(b.s_valid), 32'd1);
    chk("t5_out_empty", 32'(b.out_valid), 32'd0);
    b.s_ready = 1'b1;
    wait_drain("t5_drain");
    chk("t5_total", 32'(acc0), 32'd3);

    // Reset during flit 2 of a 4-flit packet (counters carry history from above)
    p0 = '{9'h071, 9'h072, 9'h073, 9'h174};
    for (int i = 0; i < 4; i++) src0_q.push_back(p0[i]);
    exp_s.push_back(1'b0);
    begin
      int n = 0;
      while (acc0 < 1 && n < 50) begin step(); n++; end
      chk("t6_first_flit", 32'(n < 50), 32'd1);
    end
    RESET = 1'b1;
    clear_all();
    #1;
    chk("t6_out_valid", 32'(b.out_valid), 32'd0);
    chk("t6_s_valid",   32'(b.s_valid),   32'd0);
    chk("t6_in0_ready", 32'(b.in0_ready), 32'd0);
    chk("t6_out_data",  32'(b.out_data),  32'd0);
`ifdef MERGE7_PKT_CNT_EN
    chk("t6_pkt_cnt0", 32'(pkt_cnt0), 32'd0);
`endif
    repeat (2) step();
    RESET = 1'b0;
    step();
    src0_q.push_back(9'h081); src0_q.push_back(9'h182);
    exp_out.push_back(9'h081); exp_out.push_back(9'h182);
    exp_s.push_back(1'b0);
    wait_drain("t6_drain");
`ifdef MERGE7_PKT_CNT_EN
    chk("t6_pkt_cnt0_after", 32'(pkt_cnt0), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/merge7_arbiter.md
# merge7_arbiter

Clocked two-input packet merge that sits directly downstream of the 9-bit one-hot decoder stage in the NoC router. It consumes the decoder's two output flit streams (or one stream from each of two decoders), arbitrates per packet with round-robin fairness, and forwards whole packets unbroken onto a single 9-bit output. For every granted packet it also emits a 1-bit winner index on a side channel.

## Interface
- W, 9: flit width; bit W-1 is the tail flag, bits W-2:0 are payload.
- DEPTH, 2: output flit FIFO depth; the S FIFO has the same depth; minimum 2.
- CNT_W, 16: packet counter width (used only under the configuration macro).

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in0_data  in  W  flit from input 0.
- in0_valid  in  1  input 0 flit valid.
- in0_ready  out  1  input 0 flit accepted.
- in1_data / in1_valid / in1_ready: same as input 0, for input 1.
- out_data  out  W  merged flit.
- out_valid  out  1  merged flit valid.
- out_ready  in  1  downstream accepts the merged flit.
- s_data  out  1  winner index for the next packet on the output.
- s_valid  out  1  winner index valid.
- s_ready  in  1  downstream accepts the winner index.
- pkt_cnt0, pkt_cnt1  out  CNT_W each  completed-packet counts; present only with MERGE7_PKT_CNT_EN.

## Operation
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. valid, once raised, holds with stable data until the transfer.
- FSM states: IDLE, LOCK0, LOCK1. Round-robin pointer prio resets to 0.
- IDLE: both in*_ready are 0. When at least one in*_valid is 1 and the S FIFO is not full, grant an input and move to LOCKk:
  - both inputs valid: grant prio;
  - one input valid: grant that input.
  - In the same cycle, push k into the S FIFO.
- LOCKk: ink_ready = (out FIFO count < DEPTH); the other input's ready is 0. Each transfer pushes the flit into the out FIFO.
- A transfer with tail bit = 1 returns the FSM to IDLE and sets prio = ~k. A single-flit packet (head flit is also tail) is legal.
- The other input is never interleaved mid-packet; it waits, with its valid held.
- Out FIFO and S FIFO: registered outputs; simultaneous push and pop is allowed. Ready signals depend only on registered count and state, with no combinational path from out_ready or s_ready.
- Flits are forwarded unmodified, including the tail bit.
- The S stream and the out stream are independent. S may run ahead of the flits by at most DEPTH packets; when the S FIFO is full, new grants stall in IDLE.

## Timing
- Reset values: state IDLE; prio 0; in0_ready, in1_ready, out_valid and s_valid all 0; out_data and s_data 0; FIFO counts 0; pkt_cnt* 0.
- Reset asserted mid-packet: partial packet state and FIFO contents are discarded. After release the FSM is in IDLE.
- Latency:
  - ink_valid rises at edge t while in IDLE → LOCKk and s_valid=1 after edge t+1.
  - ink_ready=1 during cycle t+1; the flit transfers at edge t+2.
  - out_valid=1 after edge t+2.
- Arbitration costs one bubble cycle per packet. Within a packet, throughput is 1 flit/cycle while out_ready stays 1, because DEPTH ≥ 2.
- Out FIFO full: ink_ready is 0 and the FSM stays in LOCKk indefinitely.

## Configuration
- MERGE7_PKT_CNT_EN defined: pkt_cnt0 and pkt_cnt1 exist.
  - pkt_cntk increments on each tail-flit transfer from input k.
  - Counters wrap modulo 2^CNT_W and reset to 0.
- Macro undefined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package merge7_pkg holds:
  - the flit typedef (tail bit + 8-bit payload);
  - the FSM state enum {IDLE, LOCK0, LOCK1};
  - the TAIL_BIT index constant.
- One sub-module, merge7_fifo: parameterised width and depth, synchronous push/pop, registered valid/data, count output. It is instantiated twice: W bits for the out FIFO and 1 bit for the S FIFO.

## Test plan
- Single 3-flit packet on in0 (0x011, 0x022, 0x133), out_ready=1 → out carries 0x011, 0x022, 0x133 in order; s_data=0 once; first out_valid 2 cycles after in0_valid.
- Both inputs present single-flit packets (0x1A0, 0x1B1) every cycle → after reset the output alternates 0x1A0, 0x1B1, 0x1A0…; S stream reads 0,1,0…
- in1 raises valid mid-packet on in0 (4 flits) → all 4 in0 flits are output contiguously before any in1 flit; in1_ready stays 0 until then.
- Hold out_ready=0 while sending 5 flits → exactly DEPTH=2 flits are accepted, then ready=0; releasing out_ready drains all 5 in order with none lost.
- Hold s_ready=0 while sending 3 single-flit packets → 2 packets are granted, the 3rd waits in IDLE; releasing s_ready grants it.
- Assert RESET during flit 2 of a 4-flit packet → all outputs and (if enabled) pkt_cnt* are 0 immediately; a fresh packet after release passes normally.
